mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/en_flop.sv | 20 ++
 rtl/wait_counter.sv | 23 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the CPU-side memory interface: state encodings and default widths.
package mem_responder_pkg;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_ADDR_WIDTH  = 10;
    localparam int DEF_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/en_flop.sv
// Enable flop with asynchronous active-low clear.
module en_flop #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wait_counter.sv
// Loadable down-counter; done flags the last wait cycle (count about to reach zero).
module wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       done
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd1);

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one request, inserts WAIT_STATES cycles, then acks.
// state | meaning
// IDLE  | no request in flight; req captures we/addr/wdata
// WAIT  | counting down wait states
// RESP  | memory accessed on entry; ack high for this one cycle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ack,
    output logic                  busy
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t                state, state_nxt;
    logic                  accept;
    logic                  enter_resp;
    logic                  cnt_done;
    logic [3:0]            cnt;
    logic                  cap_we;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0]      cap_wdata;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0]      acc_wdata;
    logic                  mem_wr;
    logic [WIDTH-1:0]      mem [DEPTH];

    assign accept = (state == ST_IDLE) && req;

    en_flop #(.WIDTH(1 + ADDR_WIDTH + WIDTH)) u_cap (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     ({we, addr, wdata}),
        .q     ({cap_we, cap_addr, cap_wdata})
    );

    wait_counter u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (WAIT_LOAD),
        .count    (cnt),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (cnt_done) begin
                    state_nxt = ST_RESP;
                end else if (cnt == 4'd0) begin
                    // unreachable in normal operation; keeps a corrupted WAIT from hanging
                    state_nxt = ST_IDLE;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accept edge, before the capture
    // registers are loaded, so the live inputs stand in for them in IDLE.
    assign acc_we    = (state == ST_IDLE) ? we    : cap_we;
    assign acc_addr  = (state == ST_IDLE) ? addr  : cap_addr;
    assign acc_wdata = (state == ST_IDLE) ? wdata : cap_wdata;

    assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);
    assign mem_wr     = enter_resp && acc_we && reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (enter_resp && !acc_we) begin
            rdata <= mem[acc_addr];
        end
    end

    assign ack  = (state == ST_RESP);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with 2 wait states, one with none.
module tb_mem_responder;

    localparam int W  = 16;
    localparam int AW = 10;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;

    logic          req_a   = 1'b0;
    logic          we_a    = 1'b0;
    logic [AW-1:0] addr_a  = '0;
    logic [W-1:0]  wdata_a = '0;
    logic [W-1:0]  rdata_a;
    logic          ack_a;
    logic          busy_a;

    logic          req_b   = 1'b0;
    logic          we_b    = 1'b0;
    logic [AW-1:0] addr_b  = '0;
    logic [W-1:0]  wdata_b = '0;
    logic [W-1:0]  rdata_b;
    logic          ack_b;
    logic          busy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_responder #(.WIDTH(W), .ADDR_WIDTH(AW), .WAIT_STATES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .req   (req_a),
        .we    (we_a),
        .addr  (addr_a),
        .wdata (wdata_a),
        .rdata (rdata_a),
        .ack   (ack_a),
        .busy  (busy_a)
    );

    mem_responder #(.WIDTH(W), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .req   (req_b),
        .we    (we_b),
        .addr  (addr_b),
        .wdata (wdata_b),
        .rdata (rdata_b),
        .ack   (ack_b),
        .busy  (busy_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Edges counted from the accept edge (inclusive) to the edge that raises ack.
    task automatic txn_a(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                         output int edges);
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        while (!ack_a && edges < 20) begin
            @(posedge clk); edges++; @(negedge clk);
        end
        req_a = 1'b0;
    endtask

    initial begin
        int e;
        int n;
        int seen;
        int lows;

        repeat (2) @(negedge clk);
        chk_eq("rst_ack",   ack_a,   0);
        chk_eq("rst_busy",  busy_a,  0);
        chk_eq("rst_rdata", rdata_a, 0);
        reset = 1'b1;

        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += ack_a + busy_a;
        end
        chk_eq("idle_activity", seen,    0);
        chk_eq("idle_rdata",    rdata_a, 16'h0000);

        txn_a(1'b1, 10'h005, 16'hBEEF, e);
        chk_eq("wr_lat",       e,       3);
        chk_eq("wr_busy_resp", busy_a,  1);
        chk_eq("wr_no_rdata",  rdata_a, 16'h0000);
        txn_a(1'b0, 10'h005, 16'h0000, e);
        chk_eq("rd_lat",  e,       3);
        chk_eq("rd_data", rdata_a, 16'hBEEF);
        txn_a(1'b1, 10'h006, 16'h6666, e);
        chk_eq("wr6_keeps_rdata", rdata_a, 16'hBEEF);

        // read of 5 with addr/we/wdata/req disturbed during WAIT
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 10'h005;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        chk_eq("mid_busy", busy_a, 1);
        req_a = 1'b0; addr_a = 10'h006; we_a = 1'b1; wdata_a = 16'hDEAD;
        while (!ack_a && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
        end
        chk_eq("mid_lat",  e,       3);
        chk_eq("mid_data", rdata_a, 16'hBEEF);
        txn_a(1'b0, 10'h006, 16'h0000, e);
        chk_eq("mid_no_write", rdata_a, 16'h6666);

        // reset during the WAIT of a write
        txn_a(1'b1, 10'h007, 16'h1111, e);
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'h007; wdata_a = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("abort_ack",   ack_a,   0);
        chk_eq("abort_busy",  busy_a,  0);
        chk_eq("abort_rdata", rdata_a, 0);
        req_a = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += ack_a;
        end
        chk_eq("abort_no_ack", seen, 0);
        reset = 1'b1;
        txn_a(1'b0, 10'h007, 16'h0000, e);
        chk_eq("abort_old_data", rdata_a, 16'h1111);

        // back-to-back: req held through ack, second request is a read-back
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b1; addr_a = 10'h008; wdata_a = 16'h5A5A;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        while (!ack_a && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
        end
        chk_eq("b2b_lat", e, 3);
        we_a = 1'b0;
        lows = 0;
        n = 0;
        do begin
            @(negedge clk);
            lows += !busy_a;
            n++;
        end while (!ack_a && n < 20);
        req_a = 1'b0;
        chk_eq("b2b_busy_gap", lows,    1);
        chk_eq("b2b_period",   n,       4);
        chk_eq("b2b_data",     rdata_a, 16'h5A5A);
        @(negedge clk);
        chk_eq("b2b_idle", busy_a, 0);

        // zero wait states: write then read of the top address with req held high
        @(negedge clk);
        req_b = 1'b1; we_b = 1'b1; addr_b = 10'h3FF; wdata_b = 16'h1234;
        @(posedge clk);
        e = 1;
        @(negedge clk);
        while (!ack_b && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
        end
        chk_eq("z_wr_lat", e, 1);
        we_b = 1'b0; wdata_b = 16'h0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_b && n < 20);
        req_b = 1'b0;
        chk_eq("z_ack_period", n,       2);
        chk_eq("z_rd_data",    rdata_b, 16'h1234);
        @(negedge clk);
        chk_eq("z_idle", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
